// File: rtl/vproc_issue_sched.sv
// vproc_issue_sched: in-order single-slot issue scheduler with a pending-write scoreboard
module vproc_issue_sched #(
    parameter int unsigned UNIT_CNT = 5,
    parameter int unsigned VREG_CNT = 32
) (
    input  logic                clk_i,
    input  logic                async_rst_ni,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [2:0]          instr_unit_i,
    input  logic [1:0]          instr_emul_i,
    input  logic                instr_rs1_vreg_i,
    input  logic [4:0]          instr_rs1_addr_i,
    input  logic                instr_rs2_vreg_i,
    input  logic [4:0]          instr_rs2_addr_i,
    input  logic                instr_vd_vreg_i,
    input  logic [4:0]          instr_vd_addr_i,
    output logic [UNIT_CNT-1:0] unit_valid_o,
    input  logic [UNIT_CNT-1:0] unit_ready_i,
    input  logic [UNIT_CNT-1:0] unit_done_i,
    output logic [VREG_CNT-1:0] pend_wr_o,
    output logic                cfg_done_o,
    output logic                illegal_o,
    output logic                busy_o
);
    // Register group A..A+2^emul-1 as a rotate of a low-bit run, so groups wrap past the top register.
    function automatic logic [VREG_CNT-1:0] grp_mask(input logic en, input logic [4:0] a, input logic [1:0] emul);
        logic [7:0]            g;
        logic [2*VREG_CNT-1:0] r;
        g = 8'hFF >> (4'd8 - (4'd1 << emul));
        r = {{(2*VREG_CNT-8){1'b0}}, g} << a;
        return en ? (r[VREG_CNT-1:0] | r[2*VREG_CNT-1:VREG_CNT]) : '0;
    endfunction

    logic                hold_q, hold_d;
    logic [2:0]          unit_q, unit_d;
    logic [VREG_CNT-1:0] rd_mask_q, rd_mask_d;
    logic [VREG_CNT-1:0] vd_mask_q, vd_mask_d;
    logic [UNIT_CNT-1:0] busy_q, busy_d;
    logic [VREG_CNT-1:0] mask_q [UNIT_CNT];
    logic [VREG_CNT-1:0] mask_d [UNIT_CNT];
    logic [VREG_CNT-1:0] pend_wr_q, pend_wr_d;
    logic [VREG_CNT-1:0] clr, vd_in;
    logic                hazard, fire, accept;

    // Dispatch/retire decisions from registered state, and next-state for hold slot and scoreboard.
    always_comb begin
        hazard = |(rd_mask_q & pend_wr_q);
        for (int u = 0; u < UNIT_CNT; u++)
            unit_valid_o[u] = hold_q & (unit_q == 3'(u)) & ~busy_q[u] & ~hazard;
        fire          = |(unit_valid_o & unit_ready_i);
        cfg_done_o    = hold_q & (unit_q == 3'd5) & ~|busy_q;
        illegal_o     = hold_q & (unit_q[2:1] == 2'b11);
        instr_ready_o = ~hold_q | fire | cfg_done_o | illegal_o;
        accept        = instr_valid_i & instr_ready_o;
        vd_in         = grp_mask(instr_vd_vreg_i, instr_vd_addr_i, instr_emul_i);
        hold_d        = accept | (hold_q & ~instr_ready_o);
        unit_d        = accept ? instr_unit_i : unit_q;
        vd_mask_d     = accept ? vd_in : vd_mask_q;
        rd_mask_d     = accept ? (vd_in | grp_mask(instr_rs1_vreg_i, instr_rs1_addr_i, instr_emul_i)
                                       | grp_mask(instr_rs2_vreg_i, instr_rs2_addr_i, instr_emul_i)) : rd_mask_q;
        busy_d        = (busy_q & ~unit_done_i) | (unit_valid_o & unit_ready_i);
        clr           = '0;
        for (int u = 0; u < UNIT_CNT; u++) begin
            clr       = clr | ((unit_done_i[u] & busy_q[u]) ? mask_q[u] : '0);
            mask_d[u] = (unit_valid_o[u] & unit_ready_i[u]) ? vd_mask_q : mask_q[u];
        end
        pend_wr_d     = (pend_wr_q & ~clr) | (fire ? vd_mask_q : '0);
    end

    assign pend_wr_o = pend_wr_q;
    assign busy_o    = hold_q | (|busy_q);

    // State registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            hold_q    <= 1'b0;
            unit_q    <= '0;
            rd_mask_q <= '0;
            vd_mask_q <= '0;
            busy_q    <= '0;
            pend_wr_q <= '0;
            for (int u = 0; u < UNIT_CNT; u++) mask_q[u] <= '0;
        end else begin
            hold_q    <= hold_d;
            unit_q    <= unit_d;
            rd_mask_q <= rd_mask_d;
            vd_mask_q <= vd_mask_d;
            busy_q    <= busy_d;
            pend_wr_q <= pend_wr_d;
            for (int u = 0; u < UNIT_CNT; u++) mask_q[u] <= mask_d[u];
        end
    end
endmodule

// File: tb/tb_vproc_issue_sched.sv
// tb_vproc_issue_sched: directed and random checks against a register-level behavioural model
module tb_vproc_issue_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv = 1'b0;
    logic        rdy_o;
    logic [2:0]  unit = '0;
    logic [1:0]  emul = '0;
    logic        rs1v = 1'b0, rs2v = 1'b0, vdv = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, vd = '0;
    logic [4:0]  uvalid, uready = '1, udone = '0;
    logic [31:0] pend;
    logic        cfg_done, illegal, busy;

    int n_chk = 0;
    int n_pass = 0;

    vproc_issue_sched dut (
        .clk_i(clk), .async_rst_ni(rst_n),
        .instr_valid_i(iv), .instr_ready_o(rdy_o), .instr_unit_i(unit), .instr_emul_i(emul),
        .instr_rs1_vreg_i(rs1v), .instr_rs1_addr_i(rs1), .instr_rs2_vreg_i(rs2v), .instr_rs2_addr_i(rs2),
        .instr_vd_vreg_i(vdv), .instr_vd_addr_i(vd),
        .unit_valid_o(uvalid), .unit_ready_i(uready), .unit_done_i(udone),
        .pend_wr_o(pend), .cfg_done_o(cfg_done), .illegal_o(illegal), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Model: held instruction, per-unit busy flag and the registers each busy unit will write.
    bit          m_hold;
    int          m_unit;
    bit [31:0]   m_rd, m_vd;
    bit          m_busy [5];
    bit [31:0]   m_wr [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic bit [31:0] regs(input bit en, input int a, input int e);
        bit [31:0] m = 0;
        if (en) for (int i = 0; i < (1 << e); i++) m[(a + i) % 32] = 1'b1;
        return m;
    endfunction

    function automatic bit [31:0] m_pend();
        bit [31:0] p = 0;
        for (int u = 0; u < 5; u++) if (m_busy[u]) p |= m_wr[u];
        return p;
    endfunction

    function automatic void m_reset();
        m_hold = 0; m_unit = 0; m_rd = 0; m_vd = 0;
        for (int u = 0; u < 5; u++) begin m_busy[u] = 0; m_wr[u] = 0; end
    endfunction

    task automatic idle();
        iv = 0; uready = '1; udone = '0;
    endtask

    task automatic instr(input int u, input int e, input bit a1v, input int a1, input bit a2v, input int a2,
                         input bit dv, input int d);
        iv = 1; unit = 3'(u); emul = 2'(e);
        rs1v = a1v; rs1 = 5'(a1); rs2v = a2v; rs2 = 5'(a2); vdv = dv; vd = 5'(d);
    endtask

    // Compare every output with the model for this cycle, advance the model, move to the next cycle.
    task automatic step();
        bit [4:0] ev;
        bit       fire, cfg, ill, rdy, anyb;
        #1;
        anyb = 0;
        for (int u = 0; u < 5; u++) anyb |= m_busy[u];
        ev = 0;
        if (m_hold && m_unit < 5 && !m_busy[m_unit] && (m_rd & m_pend()) == 0) ev[m_unit] = 1'b1;
        fire = (ev & uready) != 0;
        cfg  = m_hold && m_unit == 5 && !anyb;
        ill  = m_hold && m_unit > 5;
        rdy  = !m_hold || fire || cfg || ill;
        check("unit_valid", 32'(uvalid), 32'(ev));
        check("instr_ready", 32'(rdy_o), 32'(rdy));
        check("pend_wr", pend, m_pend());
        check("cfg_done", 32'(cfg_done), 32'(cfg));
        check("illegal", 32'(illegal), 32'(ill));
        check("busy", 32'(busy), 32'(m_hold || anyb));
        for (int u = 0; u < 5; u++) if (udone[u]) m_busy[u] = 0;
        if (fire) begin m_busy[m_unit] = 1; m_wr[m_unit] = m_vd; end
        if (iv && rdy) begin
            m_hold = 1; m_unit = int'(unit);
            m_vd = regs(vdv, vd, emul);
            m_rd = m_vd | regs(rs1v, rs1, emul) | regs(rs2v, rs2, emul);
        end else if (rdy) m_hold = 0;
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (8) begin idle(); udone = '1; step(); end
        idle();
    endtask

    initial begin
        m_reset();
        #1;
        check("rst_valid", 32'(uvalid), 0);
        check("rst_ready", 32'(rdy_o), 1);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk); rst_n = 1; @(negedge clk);
        // ALU writes v4
        instr(1, 0, 0, 0, 0, 0, 1, 4); step();
        idle(); #1 check("alu_valid", 32'(uvalid), 32'h2); step();
        idle(); #1 check("alu_pend", pend, 32'h10); udone = 5'b00010; step();
        idle(); #1 check("alu_release", pend, 0); step();
        // RAW: MUL writes v8..v9, ALU reads v9
        instr(2, 1, 0, 0, 0, 0, 1, 8); step();
        instr(1, 0, 0, 0, 1, 9, 0, 0); step();
        idle(); #1 check("raw_pend", pend, 32'h300); check("raw_stall", 32'(uvalid), 0); step();
        idle(); udone = 5'b00100; step();
        idle(); step(); idle(); step();
        drain();
        // wrap: SLD writes v30..v1, ALU reading v1 stalls
        instr(3, 2, 0, 0, 0, 0, 1, 30); step();
        idle(); step();
        instr(1, 0, 1, 1, 0, 0, 0, 0); step();
        idle(); #1 check("wrap_pend", pend, 32'hC0000003); check("wrap_stall", 32'(uvalid), 0); step();
        drain();
        // unit busy: two LSU ops to v2 and v3
        instr(0, 0, 0, 0, 0, 0, 1, 2); step();
        instr(0, 0, 0, 0, 0, 0, 1, 3); step();
        idle(); #1 check("lsu_wait", 32'(uvalid), 0); step();
        idle(); udone = 5'b00001; step();
        idle(); #1 check("lsu_second", 32'(uvalid), 32'h1); step();
        drain();
        // UNIT_CFG behind busy SLD and ELEM
        instr(3, 0, 0, 0, 0, 0, 1, 10); step();
        instr(4, 0, 0, 0, 0, 0, 1, 12); step();
        instr(5, 0, 0, 0, 0, 0, 0, 0); step();
        idle(); #1 check("cfg_wait0", 32'(cfg_done), 0); step();
        idle(); udone = 5'b01000; #1 check("cfg_wait1", 32'(cfg_done), 0); step();
        idle(); udone = 5'b10000; #1 check("cfg_wait2", 32'(cfg_done), 0); step();
        idle(); #1 check("cfg_done", 32'(cfg_done), 1); check("cfg_ready", 32'(rdy_o), 1); step();
        drain();
        // illegal code
        instr(6, 0, 0, 0, 0, 0, 1, 5); step();
        idle(); #1 check("illegal_pulse", 32'(illegal), 1); step();
        drain();
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            instr($urandom % 8, $urandom % 4, $urandom % 2, $urandom % 32, $urandom % 2, $urandom % 32,
                  $urandom % 2, $urandom % 32);
            iv = ($urandom % 4) != 0;
            uready = 5'($urandom);
            for (int u = 0; u < 5; u++) udone[u] = ($urandom % 4) == 0;
            step();
        end
        drain();
        // async reset with MUL busy and an instruction held
        instr(2, 1, 0, 0, 0, 0, 1, 8); step();
        instr(1, 0, 0, 0, 1, 9, 0, 0); step();
        idle(); #2 rst_n = 0; #1;
        check("ar_valid", 32'(uvalid), 0);
        check("ar_ready", 32'(rdy_o), 1);
        check("ar_pend", pend, 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_cfg", 32'(cfg_done), 0);
        check("ar_illegal", 32'(illegal), 0);
        m_reset();
        @(negedge clk); rst_n = 1;
        idle(); udone = 5'b00100; step();
        idle(); #1 check("ar_late_done", pend, 0); step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
